// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types, widths and note pitch table for the tone player
package music_pkg;

    // The half-period table below counts cycles of this clock.
    localparam int CLK_HZ = 50_000_000;
    localparam int HALF_W = 17;

    typedef enum logic [1:0] {IDLE, WAIT, NOTE, REST} player_state_t;

    // Half-period in CLK_HZ cycles for digits 0-9 (C4..E5); non-BCD digits give 0 (silence).
    function automatic logic [HALF_W-1:0] note_half_period(input logic [3:0] d);
        case (d)
            4'd0:    return 17'd95556;
            4'd1:    return 17'd85131;
            4'd2:    return 17'd75843;
            4'd3:    return 17'd71586;
            4'd4:    return 17'd63776;
            4'd5:    return 17'd56818;
            4'd6:    return 17'd50619;
            4'd7:    return 17'd47778;
            4'd8:    return 17'd42566;
            4'd9:    return 17'd37921;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - half-period counter and toggle producing a square-wave tone
module tone_gen
    import music_pkg::*;
(
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              ien,
    input  logic [HALF_W-1:0] ihalf,
    output logic              osq
);

    logic [HALF_W-1:0] cnt;

    // Count cycles while enabled and flip the output every ihalf cycles; idle low otherwise.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt <= '0;
            osq <= 1'b0;
        end else if (!ien || ihalf == '0) begin
            cnt <= '0;
            osq <= 1'b0;
        end else if (cnt == ihalf - HALF_W'(1)) begin
            cnt <= '0;
            osq <= ~osq;
        end else begin
            cnt <= cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/digit_tone_player.sv
// rtl/digit_tone_player.sv - plays each BCD digit of a captured word as a timed note
module digit_tone_player
    import music_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int NOTE_BEATS = 2,
    parameter int REST_BEATS = 1,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    iclk,
    input  logic                    irst_n,
    input  logic                    ibeat,
    input  logic [4*NUM_DIGITS-1:0] idigits,
    input  logic                    ivalid,
    output logic                    oready,
    output logic                    obusy,
    output logic [IDX_W-1:0]        odigit_idx,
    output logic                    ospeaker
);

    localparam int MAX_BEATS = (NOTE_BEATS > REST_BEATS) ? NOTE_BEATS : REST_BEATS;
    localparam int BC_W      = $clog2(MAX_BEATS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  NOTE_LAST = BC_W'(NOTE_BEATS - 1);
    localparam logic [BC_W-1:0]  REST_LAST = BC_W'(REST_BEATS - 1);

    logic                    beat_s1, beat_s2, beat_d;
    logic                    tick;
    player_state_t           state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BC_W-1:0]         bc_q, bc_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [3:0]              cur_digit;
    logic                    tone_en;

    // Bring the beat level into iclk through two flops, then keep one more copy for edge detect.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            beat_s1 <= 1'b0;
            beat_s2 <= 1'b0;
            beat_d  <= 1'b0;
        end else begin
            beat_s1 <= ibeat;
            beat_s2 <= beat_s1;
            beat_d  <= beat_s2;
        end
    end

    assign tick = beat_s2 & ~beat_d;

    // Player state, digit index, beat count and the captured word.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bc_q     <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bc_q     <= bc_d;
            digits_q <= digits_d;
        end
    end

    // Next-state logic: capture in IDLE, then walk NOTE/REST per digit, advancing only on ticks.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bc_d     = bc_q;
        digits_d = digits_q;
        case (state_q)
            IDLE: begin
                if (ivalid) begin
                    digits_d = idigits;
                    idx_d    = '0;
                    bc_d     = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    bc_d    = '0;
                    state_d = NOTE;
                end
            end
            NOTE: begin
                if (tick) begin
                    if (bc_q == NOTE_LAST) begin
                        bc_d    = '0;
                        state_d = REST;
                    end else begin
                        bc_d = bc_q + BC_W'(1);
                    end
                end
            end
            REST: begin
                if (tick) begin
                    if (bc_q == REST_LAST) begin
                        bc_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = NOTE;
                        end
                    end else begin
                        bc_d = bc_q + BC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pick the digit being played, MSD at index 0.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = digits_q[4*(NUM_DIGITS-1-i) +: 4];
            end
        end
    end

    // Holding the tone generator off on the entry cycle restarts its counter for every note,
    // and dropping it on the exit cycle silences the registered output together with REST.
    assign tone_en = (state_q == NOTE) && (state_d == NOTE);

    tone_gen u_tone (
        .iclk   (iclk),
        .irst_n (irst_n),
        .ien    (tone_en),
        .ihalf  (note_half_period(cur_digit)),
        .osq    (ospeaker)
    );

    assign oready     = (state_q == IDLE);
    assign obusy      = (state_q != IDLE);
    assign odigit_idx = idx_q;

endmodule

// File: tb/tb_digit_tone_player.sv
// tb/tb_digit_tone_player.sv - randomized bench against a tick-counting playback model
module tb_digit_tone_player;

    localparam int N     = 4;
    localparam int NB    = 2;
    localparam int RB    = 1;
    localparam int PER   = NB + RB;
    localparam int TOTAL = 1 + N * PER;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        ibeat;
    logic [15:0] idigits;
    logic        ivalid;
    logic        oready;
    logic        obusy;
    logic [1:0]  odigit_idx;
    logic        ospeaker;

    always #10 iclk = ~iclk;

    digit_tone_player #(
        .NUM_DIGITS (N),
        .NOTE_BEATS (NB),
        .REST_BEATS (RB)
    ) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ibeat      (ibeat),
        .idigits    (idigits),
        .ivalid     (ivalid),
        .oready     (oready),
        .obusy      (obusy),
        .odigit_idx (odigit_idx),
        .ospeaker   (ospeaker)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    int half_tab [10] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778, 42566, 37921};

    // Model: playback position is just the number of beat ticks seen since capture.
    bit          m_busy;
    int          m_k;
    int          m_idx;
    bit          m_in_note;
    int          m_cyc;
    bit          exp_spk;
    logic [15:0] m_digits;
    bit          h1, h2, h3;

    task automatic model_reset();
        m_busy    = 0;
        m_k       = 0;
        m_idx     = 0;
        m_in_note = 0;
        m_cyc     = 0;
        exp_spk   = 0;
        m_digits  = '0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_step();
        bit tk;
        bit prev_note;
        int j;
        int d;
        int half;
        tk = h2 && !h3;
        h3 = h2; h2 = h1; h1 = ibeat;
        prev_note = m_in_note;
        if (!m_busy) begin
            if (ivalid) begin
                m_busy   = 1;
                m_k      = 0;
                m_digits = idigits;
                m_idx    = 0;
            end
        end else if (tk) begin
            m_k++;
            if (m_k == TOTAL) m_busy = 0;
        end
        m_in_note = 0;
        if (m_busy && m_k >= 1) begin
            j         = m_k - 1;
            m_idx     = j / PER;
            m_in_note = (j % PER) < NB;
        end
        if (m_in_note) begin
            if (!prev_note) m_cyc = 0;
            else            m_cyc++;
            d    = int'((m_digits >> (4 * (N - 1 - m_idx))) & 16'hF);
            half = (d <= 9) ? half_tab[d] : 0;
            exp_spk = (half == 0) ? 1'b0 : bit'((m_cyc / half) % 2);
        end else begin
            exp_spk = 0;
        end
    endtask

    task automatic compare_all();
        if (n_fail < 20) begin
            check("oready", 32'(oready), 32'(!m_busy));
            check("obusy", 32'(obusy), 32'(m_busy));
            check("idx", 32'(odigit_idx), 32'(m_idx));
            check("speaker", 32'(ospeaker), 32'(exp_spk));
        end
    endtask

    task automatic do_cycle();
        @(posedge iclk);
        model_step();
        @(negedge iclk);
        compare_all();
    endtask

    task automatic pulse(input int hi, input int lo);
        ibeat = 1'b1;
        repeat (hi) do_cycle();
        ibeat = 1'b0;
        repeat (lo) do_cycle();
    endtask

    initial begin
        int cd;
        irst_n  = 1'b0;
        ibeat   = 1'b0;
        ivalid  = 1'b0;
        idigits = '0;
        model_reset();
        repeat (3) @(negedge iclk);
        check("rst_ready", 32'(oready), 32'd1);
        check("rst_busy", 32'(obusy), 32'd0);
        check("rst_idx", 32'(odigit_idx), 32'd0);
        check("rst_spk", 32'(ospeaker), 32'd0);
        irst_n = 1'b1;

        // Long first note on digit 9 so one full half-period is observed, then reset mid-note.
        idigits = 16'h9AAA;
        ivalid  = 1'b1;
        do_cycle();
        ivalid  = 1'b0;
        pulse(3, 3);
        repeat (38500) do_cycle();
        check("pre_rst_spk", 32'(ospeaker), 32'd1);
        check("pre_rst_busy", 32'(obusy), 32'd1);
        #2 irst_n = 1'b0;
        #1;
        check("mid_rst_spk", 32'(ospeaker), 32'd0);
        check("mid_rst_busy", 32'(obusy), 32'd0);
        check("mid_rst_ready", 32'(oready), 32'd1);
        check("mid_rst_idx", 32'(odigit_idx), 32'd0);
        repeat (3) @(negedge iclk);
        model_reset();
        irst_n = 1'b1;

        // Random beats, captures, busy-time ivalid, non-BCD digits and sub-cycle glitches.
        cd = 5;
        for (int c = 0; c < 15000; c++) begin
            ivalid  = ($urandom_range(0, 15) == 0);
            idigits = 16'($urandom);
            if (cd == 0) begin
                ibeat = ~ibeat;
                cd    = $urandom_range(2, 25);
            end else begin
                cd--;
            end
            if ($urandom_range(0, 49) == 0) begin
                ibeat = ~ibeat;
                #3 ibeat = ~ibeat;
            end
            do_cycle();
        end

        // Drain, then capture on the same edge a tick lands in IDLE.
        ivalid = 1'b0;
        ibeat  = 1'b0;
        for (int p = 0; p < 200 && m_busy; p++) pulse(3, 3);
        check("drain_idle", 32'(obusy), 32'd0);
        repeat (3) do_cycle();
        ibeat = 1'b1;
        do_cycle();
        do_cycle();
        ivalid  = 1'b1;
        idigits = 16'h1234;
        do_cycle();
        ivalid  = 1'b0;
        check("cap_tick_busy", 32'(obusy), 32'd1);
        ibeat = 1'b0;
        repeat (3) do_cycle();
        for (int p = 0; p < TOTAL + 1; p++) pulse(3, 3);
        check("cap_tick_done", 32'(oready), 32'd1);
        repeat (5) do_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
